// File: rtl/alu_seq_md.sv
// alu_seq_md: handshaked integer ALU with iterative multiply/divide.
// Single-cycle ops register their result on the accepting edge.
// MUL*/DIV*/REM* run one shift-add or restoring-subtract step per cycle
// over XLEN cycles on magnitudes. The sign is fixed up on the final step.
module alu_seq_md #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [SHW-1:0]  cnt;
  logic [4:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] hi, lo, mcand;

  logic [XLEN-1:0] sc_res;
  logic            sc_br;
  logic            lt_s, lt_u, eq;
  logic [XLEN-1:0] upper_b;
  logic            is_md;

  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] set_lo, set_mcand;
  logic            set_neg;

  logic            is_div;
  logic [XLEN:0]   msum, drem, ddiff;
  logic [XLEN-1:0] nxt_hi, nxt_lo;
  logic [XLEN-1:0] hi_neg;
  logic [XLEN-1:0] md_res;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign lt_s    = $signed(operand_a) < $signed(operand_b);
  assign lt_u    = operand_a < operand_b;
  assign eq      = operand_a == operand_b;
  assign upper_b = {operand_b[XLEN-1:12], 12'b0};
  assign is_md   = (op >= 5'd20) && (op <= 5'd27);

  // Single-cycle result and branch outcome from the live request
  always_comb begin
    sc_res = '0;
    sc_br  = 1'b0;
    case (op)
      5'd0:  sc_res = upper_b;
      5'd1:  sc_res = operand_a + upper_b;
      5'd2:  sc_res = operand_a + operand_b;
      5'd3:  sc_br  = eq;
      5'd4:  sc_br  = !eq;
      5'd5:  sc_br  = lt_s;
      5'd6:  sc_br  = !lt_s;
      5'd7:  sc_br  = lt_u;
      5'd8:  sc_br  = !lt_u;
      5'd9:  sc_res = {{(XLEN-1){1'b0}}, lt_s};
      5'd10: sc_res = {{(XLEN-1){1'b0}}, lt_u};
      5'd11: sc_res = operand_a ^ operand_b;
      5'd12: sc_res = operand_a | operand_b;
      5'd13: sc_res = operand_a & operand_b;
      5'd14: sc_res = operand_a << operand_b[SHW-1:0];
      5'd15: sc_res = operand_a >> operand_b[SHW-1:0];
      5'd16: sc_res = $signed(operand_a) >>> operand_b[SHW-1:0];
      5'd17: sc_res = operand_a - operand_b;
      5'd18: sc_res = operand_b;
      default: ;
    endcase
  end

  assign abs_a = operand_a[XLEN-1] ? -operand_a : operand_a;
  assign abs_b = operand_b[XLEN-1] ? -operand_b : operand_b;

  // Operand magnitudes and result-sign flag for the iterative unit.
  // lo holds the multiplier (mul) or dividend (div); mcand the other operand.
  always_comb begin
    set_lo    = operand_b;
    set_mcand = operand_a;
    set_neg   = 1'b0;
    case (op)
      5'd21: begin
        set_lo    = abs_b;
        set_mcand = abs_a;
        set_neg   = operand_a[XLEN-1] ^ operand_b[XLEN-1];
      end
      5'd22: begin
        set_mcand = abs_a;
        set_neg   = operand_a[XLEN-1];
      end
      5'd24: begin
        set_lo    = abs_a;
        set_mcand = abs_b;
        // divide-by-zero keeps the raw all-ones quotient
        set_neg   = (operand_a[XLEN-1] ^ operand_b[XLEN-1]) && (operand_b != '0);
      end
      5'd25, 5'd27: begin
        set_lo    = operand_a;
        set_mcand = operand_b;
      end
      5'd26: begin
        set_lo    = abs_a;
        set_mcand = abs_b;
        set_neg   = operand_a[XLEN-1];
      end
      default: ;
    endcase
  end

  assign is_div = (op_q >= 5'd24);

  // One multiply or restoring-divide step on {hi,lo}
  always_comb begin
    msum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    drem   = {hi, lo[XLEN-1]};
    ddiff  = drem - {1'b0, mcand};
    nxt_hi = msum[XLEN:1];
    nxt_lo = {msum[0], lo[XLEN-1:1]};
    if (is_div) begin
      if (!ddiff[XLEN]) begin
        nxt_hi = ddiff[XLEN-1:0];
        nxt_lo = {lo[XLEN-2:0], 1'b1};
      end else begin
        nxt_hi = drem[XLEN-1:0];
        nxt_lo = {lo[XLEN-2:0], 1'b0};
      end
    end
  end

  // High half of -{hi,lo}: ~hi plus the carry out of negating lo
  assign hi_neg = ~nxt_hi + XLEN'(nxt_lo == '0);

  // Final sign correction and half selection
  always_comb begin
    md_res = '0;
    case (op_q)
      5'd20:        md_res = nxt_lo;
      5'd21, 5'd22: md_res = neg_q ? hi_neg : nxt_hi;
      5'd23:        md_res = nxt_hi;
      5'd24:        md_res = neg_q ? -nxt_lo : nxt_lo;
      5'd25:        md_res = nxt_lo;
      5'd26:        md_res = neg_q ? -nxt_hi : nxt_hi;
      5'd27:        md_res = nxt_hi;
      default: ;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      mcand        <= '0;
      result       <= '0;
      branch_taken <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      cnt          <= '0;
      result       <= '0;
      branch_taken <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= op;
            if (is_md) begin
              state <= BUSY;
              cnt   <= '0;
              hi    <= '0;
              lo    <= set_lo;
              mcand <= set_mcand;
              neg_q <= set_neg;
            end else begin
              state        <= DONE;
              result       <= sc_res;
              branch_taken <= sc_br;
            end
          end
        end
        BUSY: begin
          hi <= nxt_hi;
          lo <= nxt_lo;
          if (cnt == SHW'(XLEN - 1)) begin
            state        <= DONE;
            cnt          <= '0;
            result       <= md_res;
            branch_taken <= 1'b0;
          end else begin
            cnt <= cnt + SHW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_md.sv
// Directed bench for alu_seq_md with a queue-based scoreboard of expected results.
module tb_alu_seq_md;

  localparam int XLEN   = 32;
  localparam int MD_LAT = XLEN + 1;

  localparam logic [4:0] OP_LUI = 5'd0,  OP_AUIPC = 5'd1, OP_ADD = 5'd2,  OP_BEQ = 5'd3;
  localparam logic [4:0] OP_BLT = 5'd5,  OP_BGE   = 5'd6, OP_BLTU = 5'd7, OP_SLT = 5'd9;
  localparam logic [4:0] OP_XOR = 5'd11, OP_SRL   = 5'd15, OP_SRA = 5'd16, OP_SUB = 5'd17;
  localparam logic [4:0] OP_PASSB = 5'd18, OP_MUL = 5'd20, OP_MULH = 5'd21, OP_MULHSU = 5'd22;
  localparam logic [4:0] OP_MULHU = 5'd23, OP_DIV = 5'd24, OP_DIVU = 5'd25, OP_REM = 5'd26;
  localparam logic [4:0] OP_REMU = 5'd27;

  logic            clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic            branch_taken, busy;
  logic [4:0]      op;
  logic [XLEN-1:0] operand_a, operand_b, result;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            br;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nerr = 0;

  alu_seq_md #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input logic [4:0] o, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (o)
      OP_MUL:   return p[31:0];
      OP_MULHU: return p[63:32];
      OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU:  return (b == 0) ? a : a % b;
      OP_SUB:   return a - b;
      OP_XOR:   return a ^ b;
      default:  return 32'h0;
    endcase
  endfunction

  // Issue one request from IDLE, follow it to DONE and back to IDLE.
  task automatic do_op(input logic [4:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] er, input logic eb, input int elat, input int hold);
    exp_t e;
    int   lat;
    logic busy_bad, held_bad;
    e.res = er;
    e.br  = eb;
    sb.push_back(e);
    chk("in_ready_idle", 64'(in_ready), 64'(1));
    op = o; operand_a = a; operand_b = b; in_valid = 1'b1;
    if (hold > 0) out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_bad = 1'b0;
    while (!out_valid && lat < 100) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(elat));
    chk("busy_during_op", 64'(busy_bad), 64'(0));
    chk("out_valid", 64'(out_valid), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (out_valid) begin
        chk("result", 64'(result), 64'(e.res));
        chk("branch_taken", 64'(branch_taken), 64'(e.br));
      end
    end
    chk("no_overlap_in_ready", 64'(in_ready), 64'(0));
    if (hold > 0) begin
      held_bad = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || result !== er || branch_taken !== eb || in_ready !== 1'b0)
          held_bad = 1'b1;
      end
      chk("backpressure_hold", 64'(held_bad), 64'(0));
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("idle_after_done", 64'(in_ready), 64'(1));
    chk("out_valid_drop", 64'(out_valid), 64'(0));
  endtask

  // Start a MUL, abort it after 10 iterations by flush or reset.
  task automatic abort_op(input logic use_rst);
    logic seen;
    op = OP_MUL; operand_a = 32'h1234_5678; operand_b = 32'h9ABC_DEF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("busy_before_abort", 64'(busy), 64'(1));
    if (use_rst) rst_n = 1'b0;
    else         flush = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    flush = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    if (use_rst) chk("abort_rst_result", 64'(result), 64'(0));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_output", 64'(seen), 64'(0));
    do_op(OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);
  endtask

  initial begin
    logic [4:0]      rop;
    logic [XLEN-1:0] ra, rb;
    logic            seen;
    logic [4:0]      rops[6];
    rops = '{OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_SUB, OP_XOR};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_branch", 64'(branch_taken), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops
    do_op(OP_ADD,   32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0, 1, 0);
    do_op(OP_BLT,   32'hFFFF_FFFF, 32'h0,          32'h0,         1'b1, 1, 0);
    do_op(OP_BLTU,  32'hFFFF_FFFF, 32'h0,          32'h0,         1'b0, 1, 0);
    do_op(OP_BGE,   32'h0000_0005, 32'h0000_0005,  32'h0,         1'b1, 1, 0);
    do_op(OP_BEQ,   32'hDEAD_BEEF, 32'hDEAD_BEEF,  32'h0,         1'b1, 1, 0);
    do_op(OP_SRA,   32'h8000_0000, 32'd31,         32'hFFFF_FFFF, 1'b0, 1, 0);
    do_op(OP_SRL,   32'h8000_0000, 32'd31,         32'h0000_0001, 1'b0, 1, 0);
    do_op(OP_SLT,   32'h8000_0000, 32'h0000_0001,  32'h0000_0001, 1'b0, 1, 0);
    do_op(OP_LUI,   32'hFFFF_FFFF, 32'h1234_5678,  32'h1234_5000, 1'b0, 1, 0);
    do_op(OP_AUIPC, 32'h0000_1000, 32'h1234_5678,  32'h1234_6000, 1'b0, 1, 0);
    do_op(OP_PASSB, 32'h1111_1111, 32'hCAFE_F00D,  32'hCAFE_F00D, 1'b0, 1, 0);
    do_op(5'd19,    32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0,         1'b0, 1, 0);
    do_op(5'd30,    32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0,         1'b0, 1, 0);

    // Multiply
    do_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MD_LAT, 0);
    do_op(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, MD_LAT, 0);
    do_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MD_LAT, 0);
    do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, MD_LAT, 0);

    // Divide corners
    do_op(OP_DIVU, 32'd7,          32'd0,          32'hFFFF_FFFF, 1'b0, MD_LAT, 0);
    do_op(OP_REMU, 32'd7,          32'd0,          32'd7,         1'b0, MD_LAT, 0);
    do_op(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b0, MD_LAT, 0);
    do_op(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,         1'b0, MD_LAT, 0);
    do_op(OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 1'b0, MD_LAT, 0);
    do_op(OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 1'b0, MD_LAT, 0);
    do_op(OP_DIV,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF, 1'b0, MD_LAT, 0);
    do_op(OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9, 1'b0, MD_LAT, 0);

    // Back-pressure
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, MD_LAT, 10);

    // Aborts
    abort_op(1'b0);
    abort_op(1'b1);

    // Flush on the accepting edge drops the request
    op = OP_ADD; operand_a = 32'd1; operand_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_in_ready", 64'(in_ready), 64'(1));
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("flush_accept_no_output", 64'(seen), 64'(0));

    // Randomised operands against a reference model
    for (int i = 0; i < 12; i++) begin
      rop = rops[i % 6];
      ra  = $urandom;
      rb  = (i == 2) ? 32'h0 : $urandom;
      do_op(rop, ra, rb, model(rop, ra, rb), 1'b0, (rop >= OP_MUL) ? MD_LAT : 1, 0);
    end

    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
